snac_snes_poller: RTL and testbench



---
 rtl/snac_pkg.sv | 51 +++++
 rtl/snac_rate_timer.sv | 57 +++++
 rtl/snac_snes_poller.sv | 163 ++++++++++++++++
 tb/tb_snac_snes_poller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snac_pkg
//  Description : Shared types, rate constants and timing helpers for the
//                SNAC SNES controller poller.
//  Revision    : 1.0 - initial release
// ============================================================================
package snac_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_LO = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Poll rates selectable through sample_rate
    localparam int unsigned RATE_HZ_60   = 60;
    localparam int unsigned RATE_HZ_250  = 250;
    localparam int unsigned RATE_HZ_500  = 500;
    localparam int unsigned RATE_HZ_1000 = 1000;

    // Counter widths: period counter covers 60 Hz at 96 MHz, half-bit covers 6 us
    localparam int PERIOD_W = 21;
    localparam int HALF_W   = 10;

    // Map the 3-bit rate select onto a poll frequency; codes 3..7 all mean 1 kHz
    function automatic int unsigned rate_to_hz(input logic [2:0] sel);
        case (sel)
            3'd0:    return RATE_HZ_60;
            3'd1:    return RATE_HZ_250;
            3'd2:    return RATE_HZ_500;
            default: return RATE_HZ_1000;
        endcase
    endfunction

    // Poll period in clock cycles
    function automatic int unsigned period_cycles(input int unsigned freq,
                                                  input int unsigned hz);
        return freq / hz;
    endfunction

    // Half-bit time (6 us) in clock cycles
    function automatic int unsigned half_bit_cycles(input int unsigned freq);
        return (freq / 1_000_000) * 6;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snac_rate_timer.sv
`default_nettype none
// ============================================================================
//  Module      : snac_rate_timer
//  Description : Free-running poll-period counter; pulses o_tick once per
//                period selected by sample_rate.
//  Revision    : 1.0 - initial release
// ============================================================================
module snac_rate_timer
    import snac_pkg::*;
#(
    parameter int unsigned MASTER_CLK_FREQ = 96_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] sample_rate,
    output logic       o_tick
);

    localparam logic [PERIOD_W-1:0] C_P0_M1 =
        PERIOD_W'(period_cycles(MASTER_CLK_FREQ, rate_to_hz(3'd0)) - 1);
    localparam logic [PERIOD_W-1:0] C_P1_M1 =
        PERIOD_W'(period_cycles(MASTER_CLK_FREQ, rate_to_hz(3'd1)) - 1);
    localparam logic [PERIOD_W-1:0] C_P2_M1 =
        PERIOD_W'(period_cycles(MASTER_CLK_FREQ, rate_to_hz(3'd2)) - 1);
    localparam logic [PERIOD_W-1:0] C_P3_M1 =
        PERIOD_W'(period_cycles(MASTER_CLK_FREQ, rate_to_hz(3'd3)) - 1);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] limit;
    logic                tick;

    // Terminal count follows the live rate select; the >= compare makes a
    // counter already past a newly shortened period wrap on the next cycle.
    always_comb begin
        case (sample_rate)
            3'd0:    limit = C_P0_M1;
            3'd1:    limit = C_P1_M1;
            3'd2:    limit = C_P2_M1;
            default: limit = C_P3_M1;
        endcase
        tick  = (cnt_q >= limit);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Period counter register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = tick;

endmodule
`default_nettype wire

// File: rtl/snac_snes_poller.sv
`default_nettype none
// ============================================================================
//  Module      : snac_snes_poller
//  Description : SNES LATCH/CLK sequencer for two controllers on the SNAC
//                port; publishes active-high 16-bit button words per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module snac_snes_poller
    import snac_pkg::*;
#(
    parameter int unsigned MASTER_CLK_FREQ = 96_000_000,
    parameter int          NBITS           = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ena,
    input  logic [2:0]       sample_rate,
    input  logic             i_p1_dat,
    input  logic             i_p2_dat,
    output logic             o_latch,
    output logic             o_clk,
    output logic [NBITS-1:0] p1_btn_state,
    output logic [NBITS-1:0] p2_btn_state,
    output logic             busy,
    output logic             o_stb
);

    localparam int                BIT_W     = $clog2(NBITS);
    localparam logic [HALF_W-1:0] C_HALF_M1 = HALF_W'(half_bit_cycles(MASTER_CLK_FREQ) - 1);
    localparam logic [BIT_W-1:0]  C_LAST    = BIT_W'(NBITS - 1);

    logic tick;

    snac_rate_timer #(
        .MASTER_CLK_FREQ (MASTER_CLK_FREQ)
    ) u_rate_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .sample_rate (sample_rate),
        .o_tick      (tick)
    );

    state_e             state_q, state_d;
    logic [HALF_W-1:0]  half_q, half_d;
    logic               latch2_q, latch2_d;   // second half of the 2H latch pulse
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [NBITS-1:0]   sh1_q, sh1_d, sh2_q, sh2_d;
    logic [NBITS-1:0]   p1_q, p1_d, p2_q, p2_d;
    logic               busy_q, busy_d;
    logic               stb_q, stb_d;
    logic [1:0]         p1_sync_q, p1_sync_d, p2_sync_q, p2_sync_d;

    // Next-state logic: synchronizers, frame sequencing and bit capture
    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        latch2_d  = latch2_q;
        bit_d     = bit_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        busy_d    = busy_q;
        stb_d     = 1'b0;
        p1_sync_d = {p1_sync_q[0], i_p1_dat};
        p2_sync_d = {p2_sync_q[0], i_p2_dat};

        case (state_q)
            ST_IDLE: begin
                if (tick && i_ena) begin
                    state_d  = ST_LATCH;
                    half_d   = '0;
                    latch2_d = 1'b0;
                    bit_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            // 2H is too long for the half-bit counter, so count H twice
            ST_LATCH: begin
                if (half_q == C_HALF_M1) begin
                    half_d   = '0;
                    latch2_d = 1'b1;
                    if (latch2_q) begin
                        state_d = ST_CLK_LO;
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            // Capture at the end of the low phase, just ahead of the rising edge
            ST_CLK_LO: begin
                if (half_q == C_HALF_M1) begin
                    half_d       = '0;
                    sh1_d[bit_q] = p1_sync_q[1];
                    sh2_d[bit_q] = p2_sync_q[1];
                    state_d      = ST_CLK_HI;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            ST_CLK_HI: begin
                if (half_q == C_HALF_M1) begin
                    half_d = '0;
                    bit_d  = bit_q + 1'b1;
                    state_d = (bit_q == C_LAST) ? ST_DONE : ST_CLK_LO;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            // Buttons are active-low on the wire; publish inverted
            ST_DONE: begin
                p1_d    = ~sh1_q;
                p2_d    = ~sh2_q;
                stb_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; synchronizers reset to the idle-high line level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            half_q    <= '0;
            latch2_q  <= 1'b0;
            bit_q     <= '0;
            sh1_q     <= '0;
            sh2_q     <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            busy_q    <= 1'b0;
            stb_q     <= 1'b0;
            p1_sync_q <= 2'b11;
            p2_sync_q <= 2'b11;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            latch2_q  <= latch2_d;
            bit_q     <= bit_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            busy_q    <= busy_d;
            stb_q     <= stb_d;
            p1_sync_q <= p1_sync_d;
            p2_sync_q <= p2_sync_d;
        end
    end

    assign o_latch      = (state_q == ST_LATCH);
    assign o_clk        = (state_q != ST_CLK_LO);
    assign p1_btn_state = p1_q;
    assign p2_btn_state = p2_q;
    assign busy         = busy_q;
    assign o_stb        = stb_q;

endmodule
`default_nettype wire

// File: tb/tb_snac_snes_poller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snac_snes_poller
//  Description : Self-checking bench for snac_snes_poller with two modelled
//                SNES controllers and a scoreboard of expected button words.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_snac_snes_poller;

    // Scaled clock keeps every rate within a short simulation
    localparam int unsigned C_FREQ      = 1_000_000;
    localparam int          C_H         = 6;
    localparam int          C_FRAME_LEN = 34 * C_H + 1;
    localparam int          C_LATCH_LEN = 2 * C_H;
    localparam int          C_P60       = C_FREQ / 60;
    localparam int          C_P250      = C_FREQ / 250;
    localparam int          C_P500      = C_FREQ / 500;
    localparam int          C_P1000     = C_FREQ / 1000;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_ena;
    logic [2:0]  sample_rate;
    logic        i_p1_dat, i_p2_dat;
    logic        o_latch, o_clk, busy, o_stb;
    logic [15:0] p1_btn_state, p2_btn_state;

    always #5 clk = ~clk;

    snac_snes_poller #(
        .MASTER_CLK_FREQ (C_FREQ),
        .NBITS           (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_ena        (i_ena),
        .sample_rate  (sample_rate),
        .i_p1_dat     (i_p1_dat),
        .i_p2_dat     (i_p2_dat),
        .o_latch      (o_latch),
        .o_clk        (o_clk),
        .p1_btn_state (p1_btn_state),
        .p2_btn_state (p2_btn_state),
        .busy         (busy),
        .o_stb        (o_stb)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Controller model: latches the pressed-button pattern, drives it active-low
    logic [15:0] pat1, pat2;
    logic [15:0] m_sh1, m_sh2;
    int          model_idx = 16;

    assign i_p1_dat = (model_idx < 16) ? ~m_sh1[model_idx[3:0]] : 1'b1;
    assign i_p2_dat = (model_idx < 16) ? ~m_sh2[model_idx[3:0]] : 1'b1;

    // Monitor and scoreboard
    logic [31:0] sb[$];
    logic [31:0] exp_w;
    int cyc = 0;
    int lr_t = 0;
    int latch_len = 0;
    int falls = 0;
    int lat_rises = 0;
    int stb_count = 0;
    int last_stb_t = 0;
    int prev_stb_t = 0;
    logic prev_latch = 1'b0;
    logic prev_oclk  = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (i_rst) begin
            sb.delete();
            prev_latch = 1'b0;
            prev_oclk  = 1'b1;
            model_idx  = 16;
        end else begin
            if (o_latch && !prev_latch) begin
                lr_t      = cyc;
                latch_len = 0;
                falls     = 0;
                lat_rises++;
                m_sh1     = pat1;
                m_sh2     = pat2;
                model_idx = 0;
                sb.push_back({pat1, pat2});
            end
            if (o_latch) latch_len++;
            if (!o_clk && prev_oclk) falls++;
            if (o_clk && !prev_oclk && model_idx < 16) model_idx++;
            if (o_stb) begin
                check("frame_len", cyc - lr_t, C_FRAME_LEN);
                check("latch_len", latch_len, C_LATCH_LEN);
                check("clk_falls", falls, 16);
                if (sb.size() == 0) begin
                    check("sb_underflow", 0, 1);
                end else begin
                    exp_w = sb.pop_front();
                    check("p1_word", {16'h0, p1_btn_state}, {16'h0, exp_w[31:16]});
                    check("p2_word", {16'h0, p2_btn_state}, {16'h0, exp_w[15:0]});
                end
                prev_stb_t = last_stb_t;
                last_stb_t = cyc;
                stb_count++;
            end
            prev_latch = o_latch;
            prev_oclk  = o_clk;
        end
    end

    task automatic wait_stb(input int budget);
        int start;
        int n;
        start = stb_count;
        n = 0;
        while (stb_count == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (stb_count == start) check("stb_timeout", 0, 1);
    endtask

    task automatic wait_latch(input int budget);
        int start;
        int n;
        start = lat_rises;
        n = 0;
        while (lat_rises == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (lat_rises == start) check("latch_timeout", 0, 1);
    endtask

    initial begin
        int n0;
        i_rst = 1'b1;
        i_ena = 1'b0;
        sample_rate = 3'd3;
        pat1 = 16'h0000;
        pat2 = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_latch", o_latch, 0);
        check("rst_oclk",  o_clk, 1);
        check("rst_p1",    p1_btn_state, 0);
        check("rst_p2",    p2_btn_state, 0);
        check("rst_busy",  busy, 0);
        check("rst_stb",   o_stb, 0);

        // Idle-high lines, 1 kHz
        i_ena = 1'b1;
        i_rst = 1'b0;
        wait_stb(3000);
        wait_stb(1500);
        check("period_r3", last_stb_t - prev_stb_t, C_P1000);

        pat1 = 16'hA5C3;
        pat2 = 16'h0001;
        wait_stb(1500);

        // 500 Hz
        sample_rate = 3'd2;
        pat1 = 16'hFFFF;
        pat2 = 16'h8000;
        wait_stb(2500);
        pat1 = 16'h5A5A;
        pat2 = 16'h0F0F;
        wait_stb(2500);
        check("period_r2", last_stb_t - prev_stb_t, C_P500);

        // 250 Hz
        sample_rate = 3'd1;
        pat1 = 16'($urandom);
        pat2 = 16'($urandom);
        wait_stb(4500);
        pat1 = 16'($urandom);
        pat2 = 16'($urandom);
        wait_stb(4500);
        check("period_r1", last_stb_t - prev_stb_t, C_P250);

        // Back to 1 kHz, then switch to 60 Hz mid-period
        sample_rate = 3'd7;
        wait_stb(1500);
        repeat (300) @(posedge clk);
        #1;
        sample_rate = 3'd0;
        pat1 = 16'h3C3C;
        pat2 = 16'hC001;
        wait_stb(20000);
        pat1 = 16'h0FF0;
        wait_stb(20000);
        check("period_r0", last_stb_t - prev_stb_t, C_P60);

        // Drop enable during bit 7: frame completes, no new latch pulses
        sample_rate = 3'd3;
        pat1 = 16'h1234;
        pat2 = 16'h8421;
        wait_latch(2000);
        repeat (2 * C_H + 14 * C_H) @(posedge clk);
        #1;
        check("b7_clk_low", o_clk, 0);
        check("b7_busy",    busy, 1);
        i_ena = 1'b0;
        wait_stb(300);
        n0 = lat_rises;
        repeat (3000) @(posedge clk);
        check("no_latch_after_ena", lat_rises - n0, 0);

        // Reset during the low phase of bit 10
        i_ena = 1'b1;
        pat1 = 16'h7E81;
        pat2 = 16'h1111;
        wait_latch(2000);
        repeat (2 * C_H + 20 * C_H) @(posedge clk);
        #1;
        check("b10_clk_low", o_clk, 0);
        i_rst = 1'b1;
        #1;
        check("mid_rst_oclk",  o_clk, 1);
        check("mid_rst_latch", o_latch, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_p1",    p1_btn_state, 0);
        check("mid_rst_p2",    p2_btn_state, 0);
        check("mid_rst_stb",   o_stb, 0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        pat1 = 16'hBEEF;
        pat2 = 16'h0420;
        wait_stb(2500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
